// File: rtl/iter_pkg.sv
// Shared types and helpers for the serial-bit deserializer stage.
package iter_pkg;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/iter_word_hold.sv
// One-entry valid/ready holding register between the bit collector and the word consumer.
module iter_word_hold
    import iter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             take,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid
);

    out_state_t       state_r;
    logic [WIDTH-1:0] word_r;

    // Holding FSM: a load always wins over a take so a same-cycle refill keeps the entry full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= OUT_EMPTY;
            word_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                OUT_EMPTY: begin
                    if (load) begin
                        state_r <= OUT_FULL;
                        word_r  <= load_word;
                    end else begin
                        state_r <= OUT_EMPTY;
                    end
                end
                OUT_FULL: begin
                    if (load) begin
                        word_r <= load_word;
                    end else if (take) begin
                        state_r <= OUT_EMPTY;
                    end else begin
                        state_r <= OUT_FULL;
                    end
                end
                default: begin
                    state_r <= OUT_EMPTY;
                end
            endcase
        end
    end

    assign word_out   = word_r;
    assign word_valid = (state_r == OUT_FULL);

endmodule

// File: rtl/iter_bit_deser.sv
// Packs the inverter's serial output into WIDTH-bit words behind a one-entry output buffer.
module iter_bit_deser
    import iter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       bit_ready,
    input  logic                       flush,
    output logic [WIDTH-1:0]           word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [cnt_w(WIDTH)-1:0]    bit_count
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_nxt_s;
    logic             last_s;
    logic             accept_s;
    logic             ready_s;

    // Handshake and next shift value; on the last bit shift_nxt_s is the complete word.
    always_comb begin
        last_s = (cnt_r == LAST_CNT);
        if (flush) begin
            ready_s = 1'b0;
        end else if (last_s && word_valid && !word_ready) begin
            ready_s = 1'b0;
        end else begin
            ready_s = 1'b1;
        end
        accept_s = bit_valid && ready_s;
        if (MSB_FIRST) begin
            shift_nxt_s = {shift_r[WIDTH-2:0], bit_in};
        end else begin
            shift_nxt_s = {bit_in, shift_r[WIDTH-1:1]};
        end
    end

    // Collector: count wraps explicitly at WIDTH-1 so non-power-of-2 widths behave.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {WIDTH{1'b0}};
        end else if (flush) begin
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            if (last_s) begin
                cnt_r   <= {CNT_W{1'b0}};
                shift_r <= {WIDTH{1'b0}};
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1'b1);
                shift_r <= shift_nxt_s;
            end
        end else begin
            cnt_r   <= cnt_r;
            shift_r <= shift_r;
        end
    end

    iter_word_hold #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_s && last_s),
        .load_word (shift_nxt_s),
        .take      (word_valid && word_ready),
        .word_out  (word_out),
        .word_valid(word_valid)
    );

    assign bit_ready = ready_s;
    assign bit_count = cnt_r;

endmodule
